bram_rd_arbiter: RTL

- Shares the single read port of the 512-bit-wide CSR BRAM between two traversal engines, one per input character stream.
- Per cycle: grants at most one requester, drives the BRAM address, and tracks each outstanding read through a latency-matched tag pipeline.
- Returns read data to the requester that issued it, with a valid strobe.
- Sits between the two traversal engines and the BRAM wrapper inside top.

---
 rtl/bram_rd_arbiter_pkg.sv | 19 +
 rtl/bram_rd_arbiter_tag_pipe.sv | 43 ++++
 rtl/bram_rd_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bram_rd_arbiter_pkg.sv
// Shared types and defaults for the CSR BRAM read-port arbiter.
package bram_rd_arbiter_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 512;

  // One bit is enough to name either traversal engine.
  typedef logic req_id_t;

  localparam req_id_t ID0 = 1'b0;
  localparam req_id_t ID1 = 1'b1;

  // One in-flight read: whether the slot carries a read, and who issued it.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/bram_rd_arbiter_tag_pipe.sv
// Latency-matched {valid, id} shift register that follows each BRAM read
// from its grant edge to the cycle its data appears on the BRAM output.
module rd_tag_pipe
  import bram_rd_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o,
  output logic    busy_o
);

  rd_tag_t [DEPTH-1:0] stage_q;

  // Shift one stage per cycle; no back-pressure, so every stage always moves.
  // NOTE: every stage is reset (not just stage 0) so that reads in flight at
  // reset are dropped instead of surfacing as stale rvalids after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample its neighbour's
      // pre-edge value, which is what makes this a shift register at all.
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

  // Busy whenever any stage carries a live read.
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_o = busy_o | stage_q[i].valid;
    end
  end

endmodule

// File: rtl/bram_rd_arbiter.sv
// Two-requester round-robin arbiter for the single read port of the 512-bit
// CSR BRAM. Grants combinationally, registers the winning address towards the
// BRAM and routes returning data back to its issuer via a tag pipeline.
// RD_LATENCY is legal in 1..4.
module bram_rd_arbiter
  import bram_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1,
  output logic              busy
);

  logic              run_q;
  req_id_t           ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt0_q, cnt1_q;
  logic              grant;
  rd_tag_t           tag_in, tag_out;

  // Hold everything quiet in reset and until the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Pick at most one winner: a lone requester wins, a tie goes to the pointer.
  // NOTE: both outputs get a default before any branch, so no path through the
  // block leaves them unassigned and no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (run_q) begin
      if (req0 && (!req1 || ptr_q == ID0)) gnt0 = 1'b1;
      else if (req1)                       gnt1 = 1'b1;
    end
  end

  assign grant = gnt0 | gnt1;

  // Next pointer favours the loser of this grant; winner's address goes out.
  always_comb begin
    ptr_d  = ptr_q;
    addr_d = addr_q;
    if (gnt0) begin
      ptr_d  = ID1;
      addr_d = addr0;
    end else if (gnt1) begin
      ptr_d  = ID0;
      addr_d = addr1;
    end
  end

  // Pointer and BRAM address register; address only moves on a grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q  <= ID0;
      addr_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
    end
  end

  // Saturating per-requester grant counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0 && cnt0_q != {CNT_W{1'b1}}) cnt0_q <= cnt0_q + 1'b1;
      if (gnt1 && cnt1_q != {CNT_W{1'b1}}) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign tag_in = '{valid: grant, id: gnt1};

  // One extra stage covers the address register in front of the BRAM.
  rd_tag_pipe #(
    .DEPTH (RD_LATENCY + 1)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (reset),
    .tag_i  (tag_in),
    .tag_o  (tag_out),
    .busy_o (busy)
  );

  assign rvalid0   = tag_out.valid && (tag_out.id == ID0);
  assign rvalid1   = tag_out.valid && (tag_out.id == ID1);
  assign rdata     = run_q ? bram_dout : '0;
  assign bram_addr = addr_q;
  assign gnt_cnt0  = cnt0_q;
  assign gnt_cnt1  = cnt1_q;

`ifndef SYNTHESIS
  // A waiting requester must keep its address until it is served or it drops.
  a_addr0_stable: assert property (@(posedge clk) disable iff (!reset)
    (req0 && !gnt0) |=> (!req0 || addr0 == $past(addr0)));
  a_addr1_stable: assert property (@(posedge clk) disable iff (!reset)
    (req1 && !gnt1) |=> (!req1 || addr1 == $past(addr1)));
  a_onehot_gnt: assert property (@(posedge clk) !(gnt0 && gnt1));
`endif

endmodule
